// File: rtl/sample_ram_arbiter.sv
// Arbitrates a single-port sample RAM between display reads (highest priority) and
// capture writes buffered in a 4-entry FIFO. Optional macro ARB_WR_BYPASS_EN lets an idle-cycle write skip the FIFO.
module sample_ram_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [DEPTH-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_data_valid,
  output logic             ram_we,
  output logic [DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_din,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [2:0]       fifo_count,
  output logic [1:0]       state
);

  // Write handshake: a write transfers on any cycle where wr_valid and wr_ready are
  // both high; the requester must hold addr/data stable while wr_valid waits on wr_ready.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } grant_t;

  grant_t                   grant;
  logic [DEPTH+WIDTH-1:0]   fifo_mem [4];
  logic [1:0]               head;
  logic [1:0]               tail;
  logic [2:0]               count;
  logic [DEPTH-1:0]         last_addr;
  logic                     rd_en_q;
  logic                     accept;
  logic                     push;
  logic                     pop;
  logic                     bypass;

  assign wr_ready = !reset && (count < 3'd4);
  assign accept   = wr_valid && wr_ready;
  assign pop      = !reset && !rd_en && (count != 3'd0);

`ifdef ARB_WR_BYPASS_EN
  assign bypass = !reset && !rd_en && (count == 3'd0) && accept;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;

  // The grant is decided from this cycle's inputs so a read never waits on a drain.
  always_comb begin
    grant    = ST_IDLE;
    ram_we   = 1'b0;
    ram_addr = last_addr;
    ram_din  = fifo_mem[head][WIDTH-1:0];
    if (reset) begin
      ram_addr = '0;
    end else if (rd_en) begin
      grant    = ST_READ;
      ram_addr = rd_addr;
    end else if (pop) begin
      grant    = ST_DRAIN;
      ram_we   = 1'b1;
      ram_addr = fifo_mem[head][DEPTH+WIDTH-1:WIDTH];
    end else if (bypass) begin
      grant    = ST_DRAIN;
      ram_we   = 1'b1;
      ram_addr = wr_addr;
      ram_din  = wr_data;
    end
  end

  assign state         = grant;
  assign fifo_count    = count;
  assign rd_data       = ram_dout;
  assign rd_data_valid = rd_en_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail] <= {wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= 2'd0;
      tail      <= 2'd0;
      count     <= 3'd0;
      last_addr <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      rd_en_q   <= rd_en;
      last_addr <= ram_addr;
      if (push) tail <= tail + 2'd1;
      if (pop)  head <= head + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
